// File: rtl/rom_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
package rom_prefetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] INST_STEP = 32'd4;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry FIFO with synchronous clear. The head is read straight out of
// storage flops, so an entry pushed in one cycle is visible the next.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Pointer, occupancy and storage update; clear wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rom_prefetch.sv
// Instruction prefetcher: issues sequential reads to a pipelined memory,
// buffers responses with their addresses, and discards in-flight responses
// after a core redirect.
module rom_prefetch
  import rom_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] discard_src;

  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  logic [63:0]   fifo_head;
  logic          fifo_push, fifo_pop;
  logic [CW:0]   credit_used;
  logic          req_fire;

  // Credit covers both buffered and in-flight words, so every response
  // always finds a free FIFO slot. Requests are gated by rst so nothing is
  // issued while reset is held.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign mem_req_o    = rst && (state_q == FETCH) && !flush_i &&
                        (credit_used < (CW+1)'(DEPTH));
  assign mem_addr_o   = fetch_pc_q;
  assign req_fire     = mem_req_o && mem_gnt_i;

  assign inst_valid_o = fifo_valid && (state_q == FETCH) && !flush_i;
  assign inst_addr_o  = fifo_head[63:32];
  assign inst_o       = fifo_head[31:0];

  assign fifo_push    = mem_rvalid_i && (state_q == FETCH) && !flush_i;
  assign fifo_pop     = inst_valid_o && inst_ready_i;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush_i),
    .push_i      (fifo_push),
    .push_data_i ({rsp_pc_q, mem_rdata_i}),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Next-state logic: a redirect overrides everything; otherwise FETCH
  // tracks requests/responses and DRAIN swallows stale responses.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    discard_src   = (state_q == FETCH) ? outstanding_q : discard_q;
    if (flush_i) begin
      // Responses still owed become discards; one arriving now is already gone.
      fetch_pc_d    = flush_addr_i;
      rsp_pc_d      = flush_addr_i;
      outstanding_d = '0;
      discard_d     = (mem_rvalid_i && (discard_src != '0)) ?
                      discard_src - CW'(1) : discard_src;
      state_d       = (discard_d != '0) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_fire) begin
            fetch_pc_d = fetch_pc_q + INST_STEP;
          end
          if (mem_rvalid_i) begin
            rsp_pc_d = rsp_pc_q + INST_STEP;
          end
          outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_rvalid_i);
        end
        DRAIN: begin
          if (mem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
          end
          if (discard_d == '0) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_rom_prefetch.sv
// Scoreboard bench for rom_prefetch: a pipelined memory model tags each
// request with a redirect epoch; current-epoch responses queue the expected
// instruction, which is compared when the core side observes it.
module tb_rom_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  rom_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_addr_i (flush_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  pend_t       mem_q[$];
  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned rv_lat = 1;
  int unsigned grants = 0;
  int unsigned dropped = 0;
  int unsigned lat;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] held_addr;
  logic        gnt_en = 1'b1;
  logic        ready = 1'b1;
  logic        flush_drv = 1'b0;
  logic [31:0] flush_tgt = '0;
  logic        last_valid = 1'b0;
  logic        saw_zero_grant = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1 time unit later (before posedge).
  task automatic cycle();
    int unsigned stale;
    pend_t       p;
    @(negedge clk);
    rst          = 1'b1;
    flush_i      = flush_drv;
    flush_addr_i = flush_tgt;
    if (flush_drv) begin
      epoch++;
      sb_q.delete();
      exp_fetch = flush_tgt;
    end
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      p = mem_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rom_word(p.addr);
      if (p.epoch == epoch) sb_q.push_back('{p.addr, rom_word(p.addr)});
      else dropped++;
    end
    mem_gnt_i    = gnt_en;
    inst_ready_i = ready;
    #1;
    if (flush_drv || stale != 0) begin
      check("req_low_flush_drain", {31'd0, mem_req_o}, 32'd0);
      check("valid_low_flush_drain", {31'd0, inst_valid_o}, 32'd0);
    end
    if (mem_req_o && mem_gnt_i) begin
      check("req_addr", mem_addr_o, exp_fetch);
      if (mem_addr_o == 32'h0) saw_zero_grant = 1'b1;
      mem_q.push_back('{mem_addr_o, epoch, cyc + rv_lat});
      exp_fetch += 32'd4;
      grants++;
    end
    if (inst_valid_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {31'd0, inst_valid_o}, 32'd0);
      end else begin
        check("inst_addr", inst_addr_o, sb_q[0].addr);
        check("inst_data", inst_o, sb_q[0].data);
        if (inst_ready_i) void'(sb_q.pop_front());
      end
    end
    last_valid = inst_valid_o;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; the memory model shares the reset.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst          = 1'b0;
    flush_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    flush_drv    = 1'b0;
    #1;
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_inst_addr", inst_addr_o, 32'd0);
    check("rst_mem_addr", mem_addr_o, RESET_PC);
    mem_q.delete();
    sb_q.delete();
    epoch++;
    exp_fetch = RESET_PC;
  endtask

  // Wait (bounded) for the first valid instruction, counting cycles.
  task automatic wait_valid(output int unsigned n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n++;
      if (last_valid) break;
    end
  endtask

  initial begin
    // Reset and first-fetch latency with a zero-wait memory.
    do_reset();
    wait_valid(lat);
    check("reset_to_first_valid", lat, 32'd3);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("stream_one_per_cycle", {31'd0, last_valid}, 32'd1);
    end

    // Core stalled: credit limits grants to DEPTH, head held.
    do_reset();
    ready  = 1'b0;
    grants = 0;
    repeat (20) cycle();
    check("grants_while_stalled", grants, DEPTH);
    check("req_low_when_full", {31'd0, mem_req_o}, 32'd0);
    check("held_inst_addr", inst_addr_o, 32'h0);
    ready = 1'b1;
    repeat (6) cycle();

    // Redirect with two requests in flight: both responses dropped.
    gnt_en = 1'b0;
    repeat (6) cycle();
    rv_lat = 5;
    gnt_en = 1'b1;
    grants = 0;
    repeat (2) cycle();
    gnt_en = 1'b0;
    check("inflight_grants", grants, 32'd2);
    dropped   = 0;
    flush_drv = 1'b1;
    flush_tgt = 32'h0000_0100;
    cycle();
    flush_drv = 1'b0;
    gnt_en    = 1'b1;
    rv_lat    = 1;
    wait_valid(lat);
    check("stale_dropped", dropped, 32'd2);
    check("first_after_flush", inst_addr_o, 32'h0000_0100);
    repeat (4) cycle();

    // Grant withheld: request and address stay stable, advance once on grant.
    gnt_en = 1'b0;
    cycle();
    held_addr = mem_addr_o;
    check("req_held", {31'd0, mem_req_o}, 32'd1);
    repeat (4) begin
      cycle();
      check("req_held", {31'd0, mem_req_o}, 32'd1);
      check("addr_held", mem_addr_o, held_addr);
    end
    gnt_en = 1'b1;
    cycle();
    check("addr_at_grant", mem_addr_o, held_addr);
    cycle();
    check("addr_after_grant", mem_addr_o, held_addr + 32'd4);
    repeat (4) cycle();

    // Address wrap plus idle redirect latency.
    gnt_en = 1'b0;
    repeat (4) cycle();
    gnt_en         = 1'b1;
    saw_zero_grant = 1'b0;
    flush_drv      = 1'b1;
    flush_tgt      = 32'hFFFF_FFF8;
    cycle();
    flush_drv = 1'b0;
    wait_valid(lat);
    check("flush_to_first_valid", lat, 32'd3);
    repeat (6) cycle();
    check("wrap_to_zero_grant", {31'd0, saw_zero_grant}, 32'd1);

    // Reset while draining stale responses.
    gnt_en = 1'b0;
    repeat (4) cycle();
    rv_lat = 5;
    gnt_en = 1'b1;
    repeat (2) cycle();
    gnt_en    = 1'b0;
    flush_drv = 1'b1;
    flush_tgt = 32'h0000_0200;
    cycle();
    flush_drv = 1'b0;
    cycle();
    do_reset();
    rv_lat = 1;
    gnt_en = 1'b1;
    cycle();
    check("first_req_after_rst", {31'd0, mem_req_o}, 32'd1);
    check("first_addr_after_rst", mem_addr_o, RESET_PC);
    repeat (8) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
